// File: rtl/conv2_layer_ctrl_pkg.sv
// Shared definitions for the conv2 layer sequencer.
// Holds the default layer geometry, the FSM state encoding and a width helper
// that keeps every counter/address field at least one bit wide.
package conv2_layer_ctrl_pkg;

  localparam int IN_DIM_D   = 12;
  localparam int K_D        = 5;
  localparam int OUT_DIM_D  = 8;
  localparam int NUM_MAPS_D = 3;
  localparam int RD_LAT_D   = 1;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

endpackage

// File: rtl/conv2_layer_ctrl_if.sv
// Bus between the conv2 sequencer, the layer scheduler and the conv2
// memories/MAC datapath.
//   start            scheduler -> sequencer, one-cycle run request
//   busy, done       sequencer -> scheduler
//   in_addr, w_addr  fmap / weight read addresses
//   mac_clr, mac_en  MAC load-first-product / accumulate strobes
//   out_we, out_addr, out_map  output-memory write port
// master = sequencer side, slave = scheduler/datapath side.
interface conv2_layer_ctrl_if
  import conv2_layer_ctrl_pkg::*;
#(
  parameter int IN_DIM   = IN_DIM_D,
  parameter int K        = K_D,
  parameter int OUT_DIM  = OUT_DIM_D,
  parameter int NUM_MAPS = NUM_MAPS_D
);

  localparam int AW_IN  = cw(IN_DIM * IN_DIM);
  localparam int AW_W   = cw(NUM_MAPS * K * K);
  localparam int AW_OUT = cw(OUT_DIM * OUT_DIM);
  localparam int AW_MAP = cw(NUM_MAPS);

  logic              start;
  logic              busy;
  logic              done;
  logic [AW_IN-1:0]  in_addr;
  logic [AW_W-1:0]   w_addr;
  logic              mac_clr;
  logic              mac_en;
  logic              out_we;
  logic [AW_OUT-1:0] out_addr;
  logic [AW_MAP-1:0] out_map;

  modport master (
    input  start,
    output busy, done, in_addr, w_addr, mac_clr, mac_en, out_we, out_addr, out_map
  );

  modport slave (
    output start,
    input  busy, done, in_addr, w_addr, mac_clr, mac_en, out_we, out_addr, out_map
  );

endinterface

// File: rtl/conv2_layer_ctrl_tap_counter.sv
// Nested tap/pixel/map counter for the conv2 sequencer.
// Order, fastest first: kx, ky (kernel tap), ox, oy (output pixel), m (map).
// Each level wraps to 0 at its maximum and advances the next level only when
// every faster level wraps in the same cycle.
//   clr         hold all counters at 0
//   en          advance by one tap
//   pix_last    current tap is the last tap of its pixel
//   layer_last  current tap is the very last tap of the layer
module conv_tap_counter
  import conv2_layer_ctrl_pkg::*;
#(
  parameter int K        = K_D,
  parameter int OUT_DIM  = OUT_DIM_D,
  parameter int NUM_MAPS = NUM_MAPS_D,
  localparam int KW = cw(K),
  localparam int PW = cw(OUT_DIM),
  localparam int MW = cw(NUM_MAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [KW-1:0] kx,
  output logic [KW-1:0] ky,
  output logic [PW-1:0] ox,
  output logic [PW-1:0] oy,
  output logic [MW-1:0] m,
  output logic          pix_last,
  output logic          layer_last
);

  logic kx_max, ky_max, ox_max, oy_max, m_max;
  logic wrap_kx, wrap_ky, wrap_ox, wrap_oy;

  assign kx_max = (kx == KW'(K - 1));
  assign ky_max = (ky == KW'(K - 1));
  assign ox_max = (ox == PW'(OUT_DIM - 1));
  assign oy_max = (oy == PW'(OUT_DIM - 1));
  assign m_max  = (m == MW'(NUM_MAPS - 1));

  // Cumulative wrap: a level carries only when all faster levels wrap too.
  assign wrap_kx = kx_max;
  assign wrap_ky = wrap_kx && ky_max;
  assign wrap_ox = wrap_ky && ox_max;
  assign wrap_oy = wrap_ox && oy_max;

  assign pix_last   = wrap_ky;
  assign layer_last = wrap_oy && m_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
      m  <= '0;
    end else if (clr) begin
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
      m  <= '0;
    end else if (en) begin
      kx <= kx_max ? '0 : kx + KW'(1);
      if (wrap_kx) ky <= ky_max ? '0 : ky + KW'(1);
      if (wrap_ky) ox <= ox_max ? '0 : ox + PW'(1);
      if (wrap_ox) oy <= oy_max ? '0 : oy + PW'(1);
      if (wrap_oy) m  <= m_max  ? '0 : m + MW'(1);
    end
  end

endmodule

// File: rtl/conv2_layer_ctrl.sv
// Convolution-2 layer sequencer.
// On start it walks NUM_MAPS maps x OUT_DIM^2 pixels x K^2 taps, one tap per
// cycle, driving fmap/weight read addresses. Issue-side strobes travel down an
// RD_LAT-deep delay line so mac_en/mac_clr line up with the read data; the
// output write is one stage later because the MAC result is registered.
// Ports: clk, reset (async, active-high), bus (conv2_layer_ctrl_if.master).
module conv2_layer_ctrl
  import conv2_layer_ctrl_pkg::*;
#(
  parameter int IN_DIM   = IN_DIM_D,
  parameter int K        = K_D,
  parameter int OUT_DIM  = OUT_DIM_D,
  parameter int NUM_MAPS = NUM_MAPS_D,
  parameter int RD_LAT   = RD_LAT_D
) (
  input  logic               clk,
  input  logic               reset,
  conv2_layer_ctrl_if.master bus
);

  localparam int AW_IN  = cw(IN_DIM * IN_DIM);
  localparam int AW_W   = cw(NUM_MAPS * K * K);
  localparam int AW_OUT = cw(OUT_DIM * OUT_DIM);
  localparam int AW_MAP = cw(NUM_MAPS);
  localparam int KW     = cw(K);
  localparam int PW     = cw(OUT_DIM);
  localparam int MW     = cw(NUM_MAPS);
  localparam int DW     = cw(RD_LAT + 1);

  state_t          state;
  logic [DW-1:0]   drain_cnt;

  logic [KW-1:0]   kx, ky;
  logic [PW-1:0]   ox, oy;
  logic [MW-1:0]   m;
  logic            pix_last, layer_last;

  logic              issue_p0;
  logic              clr_p0;
  logic              last_p0;
  logic [AW_IN-1:0]  in_addr_p0;
  logic [AW_W-1:0]   w_addr_p0;
  logic [AW_OUT-1:0] oaddr_p0;
  logic [AW_MAP-1:0] omap_p0;

  logic              vld_p1   [RD_LAT];
  logic              clr_p1   [RD_LAT];
  logic              last_p1  [RD_LAT];
  logic [AW_OUT-1:0] oaddr_p1 [RD_LAT];
  logic [AW_MAP-1:0] omap_p1  [RD_LAT];

  logic              we_p2;
  logic [AW_OUT-1:0] oaddr_p2;
  logic [AW_MAP-1:0] omap_p2;

  // Counters sit at zero whenever idle, so every run starts from tap 0 and a
  // start seen outside IDLE cannot touch them.
  conv_tap_counter #(
    .K        (K),
    .OUT_DIM  (OUT_DIM),
    .NUM_MAPS (NUM_MAPS)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == ST_IDLE),
    .en         (state == ST_ISSUE),
    .kx         (kx),
    .ky         (ky),
    .ox         (ox),
    .oy         (oy),
    .m          (m),
    .pix_last   (pix_last),
    .layer_last (layer_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (layer_last) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          // RD_LAT+1 cycles: read latency plus the registered MAC result.
          if (drain_cnt == DW'(RD_LAT)) state <= ST_FIN;
          else drain_cnt <= drain_cnt + DW'(1);
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage p0: tap issue, addresses straight from the counters.
  always_comb begin
    issue_p0   = (state == ST_ISSUE);
    in_addr_p0 = '0;
    w_addr_p0  = '0;
    if (issue_p0) begin
      in_addr_p0 = (AW_IN'(oy) + AW_IN'(ky)) * AW_IN'(IN_DIM) + AW_IN'(ox) + AW_IN'(kx);
      w_addr_p0  = AW_W'(m) * AW_W'(K * K) + AW_W'(ky) * AW_W'(K) + AW_W'(kx);
    end
    clr_p0   = issue_p0 && (kx == '0) && (ky == '0);
    last_p0  = issue_p0 && pix_last;
    oaddr_p0 = AW_OUT'(oy) * AW_OUT'(OUT_DIM) + AW_OUT'(ox);
    omap_p0  = AW_MAP'(m);
  end

  // Stage p1: RD_LAT-deep delay line, last entry aligns with read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_p1[i]   <= 1'b0;
        clr_p1[i]   <= 1'b0;
        last_p1[i]  <= 1'b0;
        oaddr_p1[i] <= '0;
        omap_p1[i]  <= '0;
      end
    end else begin
      vld_p1[0]   <= issue_p0;
      clr_p1[0]   <= clr_p0;
      last_p1[0]  <= last_p0;
      oaddr_p1[0] <= oaddr_p0;
      omap_p1[0]  <= omap_p0;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_p1[i]   <= vld_p1[i-1];
        clr_p1[i]   <= clr_p1[i-1];
        last_p1[i]  <= last_p1[i-1];
        oaddr_p1[i] <= oaddr_p1[i-1];
        omap_p1[i]  <= omap_p1[i-1];
      end
    end
  end

  // Stage p2: write-back, one cycle after the MAC absorbs the last tap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_p2    <= 1'b0;
      oaddr_p2 <= '0;
      omap_p2  <= '0;
    end else begin
      we_p2    <= vld_p1[RD_LAT-1] && last_p1[RD_LAT-1];
      oaddr_p2 <= oaddr_p1[RD_LAT-1];
      omap_p2  <= omap_p1[RD_LAT-1];
    end
  end

  assign bus.busy     = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign bus.done     = (state == ST_FIN);
  assign bus.in_addr  = in_addr_p0;
  assign bus.w_addr   = w_addr_p0;
  assign bus.mac_en   = vld_p1[RD_LAT-1];
  assign bus.mac_clr  = vld_p1[RD_LAT-1] && clr_p1[RD_LAT-1];
  assign bus.out_we   = we_p2;
  assign bus.out_addr = oaddr_p2;
  assign bus.out_map  = omap_p2;

endmodule

// File: tb/tb_conv2_layer_ctrl.sv
// Directed bench for conv2_layer_ctrl at default parameters.
// Expected output writes are queued when a run is started and popped as the
// DUT raises out_we; issue-side addresses and strobes are checked at fixed
// cycle offsets from the accepted start.
module tb_conv2_layer_ctrl;
  import conv2_layer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv2_layer_ctrl_if bus ();

  conv2_layer_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  int done_t   = 0;
  int we_cnt   = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, service scoreboard.
  task automatic tick();
    logic [7:0] exp;
    @(posedge clk);
    #1;
    t++;
    if (bus.done === 1'b1 && done_t == 0) done_t = t;
    if (bus.out_we === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(we_cnt), 32'(0));
      end else begin
        exp = sb.pop_front();
        check($sformatf("wr%0d", we_cnt), 32'({bus.out_map, bus.out_addr}), 32'(exp));
      end
    end
  endtask

  task automatic tick_to(input int n);
    while (t < n) tick();
  endtask

  task automatic push_run();
    for (int mm = 0; mm < 3; mm++)
      for (int a = 0; a < 64; a++)
        sb.push_back({2'(mm), 6'(a)});
  endtask

  // Pulse start; on return t==1, the first issue cycle.
  task automatic start_run();
    push_run();
    t      = 0;
    done_t = 0;
    we_cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_quiet(input string p);
    check({p, "_busy"},     32'(bus.busy),     32'(0));
    check({p, "_done"},     32'(bus.done),     32'(0));
    check({p, "_in_addr"},  32'(bus.in_addr),  32'(0));
    check({p, "_w_addr"},   32'(bus.w_addr),   32'(0));
    check({p, "_mac_en"},   32'(bus.mac_en),   32'(0));
    check({p, "_mac_clr"},  32'(bus.mac_clr),  32'(0));
    check({p, "_out_we"},   32'(bus.out_we),   32'(0));
    check({p, "_out_addr"}, 32'(bus.out_addr), 32'(0));
    check({p, "_out_map"},  32'(bus.out_map),  32'(0));
  endtask

  task automatic check_run_end(input string p);
    check({p, "_done_t"}, 32'(done_t),   32'(4803));
    check({p, "_we_cnt"}, 32'(we_cnt),   32'(192));
    check({p, "_sb_left"}, 32'(sb.size()), 32'(0));
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(bus.busy), 32'(0));

    // Run 1: full layer with stray start pulses mid-run and during FIN.
    start_run();
    check("t1_busy",    32'(bus.busy),    32'(1));
    check("t1_in_addr", 32'(bus.in_addr), 32'(0));
    check("t1_w_addr",  32'(bus.w_addr),  32'(0));
    check("t1_mac_en",  32'(bus.mac_en),  32'(0));
    tick();
    check("t2_in_addr", 32'(bus.in_addr), 32'(1));
    check("t2_w_addr",  32'(bus.w_addr),  32'(1));
    check("t2_mac_en",  32'(bus.mac_en),  32'(1));
    check("t2_mac_clr", 32'(bus.mac_clr), 32'(1));
    tick();
    check("t3_mac_en",  32'(bus.mac_en),  32'(1));
    check("t3_mac_clr", 32'(bus.mac_clr), 32'(0));
    tick_to(6);
    check("tap5_in_addr", 32'(bus.in_addr), 32'(12));
    check("tap5_w_addr",  32'(bus.w_addr),  32'(5));
    tick_to(26);
    check("px1_in_addr", 32'(bus.in_addr), 32'(1));
    check("px1_w_addr",  32'(bus.w_addr),  32'(0));
    check("t26_out_we",  32'(bus.out_we),  32'(0));
    tick_to(27);
    check("t27_out_we",  32'(bus.out_we),  32'(1));
    check("t27_mac_clr", 32'(bus.mac_clr), 32'(1));
    check("t27_mac_en",  32'(bus.mac_en),  32'(1));
    tick_to(100);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("px4_in_addr", 32'(bus.in_addr), 32'(4));
    check("px4_w_addr",  32'(bus.w_addr),  32'(0));
    check("t101_busy",   32'(bus.busy),    32'(1));
    tick_to(201);
    check("row1_in_addr", 32'(bus.in_addr), 32'(12));
    tick_to(1600);
    check("m0_last_in_addr", 32'(bus.in_addr), 32'(143));
    check("m0_last_w_addr",  32'(bus.w_addr),  32'(24));
    tick();
    check("m1_first_in_addr", 32'(bus.in_addr), 32'(0));
    check("m1_first_w_addr",  32'(bus.w_addr),  32'(25));
    tick_to(4800);
    check("last_in_addr", 32'(bus.in_addr), 32'(143));
    check("last_w_addr",  32'(bus.w_addr),  32'(74));
    tick();
    check("t4801_in_addr", 32'(bus.in_addr), 32'(0));
    check("t4801_mac_en",  32'(bus.mac_en),  32'(1));
    check("t4801_busy",    32'(bus.busy),    32'(1));
    tick();
    check("t4802_mac_en", 32'(bus.mac_en), 32'(0));
    check("t4802_out_we", 32'(bus.out_we), 32'(1));
    check("t4802_done",   32'(bus.done),   32'(0));
    tick();
    check("t4803_done",   32'(bus.done),   32'(1));
    check("t4803_mac_en", 32'(bus.mac_en), 32'(0));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("fin_start_busy", 32'(bus.busy), 32'(0));
    check("fin_start_done", 32'(bus.done), 32'(0));
    tick();
    check("t4805_busy",    32'(bus.busy),    32'(0));
    check("t4805_in_addr", 32'(bus.in_addr), 32'(0));
    check_run_end("run1");

    // Run 2: reset mid-run.
    start_run();
    tick_to(1000);
    check("run2_no_done", 32'(done_t), 32'(0));
    reset = 1'b1;
    #1;
    check_quiet("mid_reset");
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_busy", 32'(bus.busy), 32'(0));

    // Run 3: clean full run after the reset.
    start_run();
    check("run3_t1_busy", 32'(bus.busy), 32'(1));
    tick_to(4805);
    check("run3_idle", 32'(bus.busy), 32'(0));
    check_run_end("run3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
